// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial link blocks.
//   state_t    - receiver frame-tracking states (also exported for debug)
//   bit_period - number of clk cycles per line bit for a given timer width
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    function automatic int unsigned bit_period(input int unsigned timer_width);
        return 32'd1 << timer_width;
    endfunction

endpackage

// File: rtl/serial_rx_if.sv
// serial_rx_if: consumer-side bundle of the serial receiver.
//   ack       - consumer has taken Q (driven by the consumer)
//   Q         - last good word, first line bit in Q[Width-1]
//   valid     - Q holds an unread word
//   busy      - a frame is being received
//   frame_err - one-cycle pulse, stop bit sampled low
//   overrun   - sticky, a good word replaced an unread one
//   state     - receiver FSM state, for observation only
//
// Handshake: valid is a level. It rises the cycle after a good stop bit and
// stays high until a cycle where ack=1 is sampled; ack with valid=0 has no
// effect. A new word arriving while valid=1 overwrites Q and raises overrun
// unless ack is sampled on that same cycle (the old word counts as taken).
interface serial_rx_if #(parameter int Width = 8);
    import serial_pkg::*;

    logic             ack;
    logic [0:Width-1] Q;
    logic             valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    state_t           state;

    modport master (input ack, output Q, valid, busy, frame_err, overrun, state);
    modport slave  (output ack, input Q, valid, busy, frame_err, overrun, state);

endinterface

// File: rtl/serial_sync.sv
// serial_sync: two-flop synchroniser for one asynchronous input.
//   clk, rst - clock, asynchronous active-high reset
//   d_i      - asynchronous input
//   q_o      - synchronised copy, two cycles of latency
// Resets to 1 so an idle serial line does not look like a start bit.
module serial_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// serial_rx: UART-style receiver, start bit 0, Width data bits, stop bit 1,
// 2^TimerWidth clk cycles per bit.
//   clk, rst - clock, asynchronous active-high reset
//   rx       - serial line, asynchronous, idle high
//   bus      - consumer handshake (ack/Q/valid/busy/frame_err/overrun/state)
module serial_rx
    import serial_pkg::*;
#(
    parameter int Width      = 8,
    parameter int TimerWidth = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    serial_rx_if.master  bus
);

    localparam int CntW = $clog2(Width + 1);
    // START checks the line half a bit after the falling edge was seen.
    localparam logic [TimerWidth-1:0] MID_BIT  = TimerWidth'(bit_period(TimerWidth - 1) - 1);
    localparam logic [CntW-1:0]       CNT_LAST = CntW'(Width - 1);

    logic                  rxs;
    state_t                state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [CntW-1:0]       bitcnt_q, bitcnt_d;
    logic [0:Width-1]      shift_q, shift_d;
    logic [0:Width-1]      q_q, q_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  good_stop;

    serial_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            q_q      <= q_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;   // free-running; wraps mod 2^TimerWidth
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        q_d       = q_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;
        good_stop = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (timer_q == MID_BIT) begin
                    timer_d  = '0;
                    bitcnt_d = '0;
                    // A start bit that is already gone at mid-bit was a glitch.
                    state_d  = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == '1) begin
                    // Shift towards higher indices: first line bit ends in Q[Width-1].
                    shift_d  = {rxs, shift_q[0:Width-2]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == CNT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (timer_q == '1) begin
                    if (rxs) begin
                        good_stop = 1'b1;
                        state_d   = IDLE;   // leave at mid-stop to catch back-to-back starts
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                timer_d = '0;
                // A held-low (break) line must return high before re-arming.
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (good_stop) begin
            q_d     = shift_q;
            valid_d = 1'b1;
            // A same-cycle ack consumes the old word, so it is not an overrun.
            if (bus.ack)      ovr_d = 1'b0;
            else if (valid_q) ovr_d = 1'b1;
        end else if (bus.ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign bus.Q         = q_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;
    import serial_pkg::*;

    logic clk;
    logic rst;
    logic rx;
    logic rx8;

    int checks = 0;
    int errors = 0;

    int ferr_cnt  = 0;
    int data_cnt  = 0;
    int start_cnt = 0;

    serial_rx_if #(.Width(8)) bus  ();
    serial_rx_if #(.Width(8)) bus8 ();

    serial_rx #(.Width(8), .TimerWidth(4)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus.master)
    );

    serial_rx #(.Width(8), .TimerWidth(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .rx  (rx8),
        .bus (bus8.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.state == DATA) data_cnt++;
        if (bus.state == START) start_cnt++;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_line(input bit slow, input logic v);
        if (slow) rx8 = v;
        else      rx  = v;
    endtask

    // Called on a negedge; returns on the negedge after the stop bit ends,
    // leaving the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit slow);
        int per;
        per = slow ? 256 : 16;
        drive_line(slow, 1'b0);
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive_line(slow, data[i]);
            repeat (per) @(negedge clk);
        end
        drive_line(slow, stop_bit);
        repeat (per) @(negedge clk);
    endtask

    task automatic pulse_ack(input bit slow);
        if (slow) bus8.ack = 1'b1;
        else      bus.ack  = 1'b1;
        @(negedge clk);
        bus.ack  = 1'b0;
        bus8.ack = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       do_ack;
        logic [7:0] exp_q;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] got_q;
    int         base_f;
    int         base_d;
    int         base_s;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0};
        vecs[3] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1};
        vecs[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 0};
        vecs[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 0};

        rst = 1'b1;
        rx  = 1'b1;
        rx8 = 1'b1;
        bus.ack  = 1'b0;
        bus8.ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        got_q = bus.Q;
        check("rst_q", got_q, 8'h00);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ferr", bus.frame_err, 1'b0);
        check("rst_ovr", bus.overrun, 1'b0);
        check("rst_state", bus.state, IDLE);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Short low glitch: enters START only, rejected at mid-bit
        base_d = data_cnt;
        base_s = start_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_start_seen", (start_cnt != base_s), 1'b1);
        check("glitch_no_data", data_cnt - base_d, 0);
        check("glitch_busy", bus.busy, 1'b0);
        check("glitch_valid", bus.valid, 1'b0);

        // Bad stop bit then break line, then recovery
        base_f = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        check("brk_ferr_cycles", ferr_cnt - base_f, 1);
        check("brk_valid", bus.valid, 1'b0);
        got_q = bus.Q;
        check("brk_q", got_q, 8'h00);
        base_d = data_cnt;
        repeat (100) @(negedge clk);
        check("brk_no_data", data_cnt - base_d, 0);
        check("brk_state", bus.state, WAIT_IDLE);
        check("brk_busy", bus.busy, 1'b0);
        check("brk_valid2", bus.valid, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h11, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        got_q = bus.Q;
        check("rec_q", got_q, 8'h11);
        check("rec_valid", bus.valid, 1'b1);
        pulse_ack(1'b0);
        check("rec_ack_valid", bus.valid, 1'b0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            base_f = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
            rx = 1'b1;
            repeat (4) @(negedge clk);
            got_q = bus.Q;
            check($sformatf("v%0d_q", i), got_q, vecs[i].exp_q);
            check($sformatf("v%0d_valid", i), bus.valid, vecs[i].exp_valid);
            check($sformatf("v%0d_ovr", i), bus.overrun, vecs[i].exp_ovr);
            check($sformatf("v%0d_ferr", i), ferr_cnt - base_f, vecs[i].exp_ferr);
            check($sformatf("v%0d_busy", i), bus.busy, 1'b0);
            if (vecs[i].do_ack) begin
                pulse_ack(1'b0);
                check($sformatf("v%0d_ack_valid", i), bus.valid, 1'b0);
                check($sformatf("v%0d_ack_ovr", i), bus.overrun, 1'b0);
            end
        end

        // ack on the exact cycle the second word loads
        send_frame(8'h01, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("sc_first_valid", bus.valid, 1'b1);
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                // load edge is the 155th posedge after the start-bit negedge
                repeat (154) @(negedge clk);
                bus.ack = 1'b1;
                @(negedge clk);
                bus.ack = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        got_q = bus.Q;
        check("sc_q", got_q, 8'h22);
        check("sc_valid", bus.valid, 1'b1);
        check("sc_ovr", bus.overrun, 1'b0);

        // Async reset mid-data of 0xFF (valid still 1 from the word above)
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        got_q = bus.Q;
        check("arst_q", got_q, 8'h00);
        check("arst_valid", bus.valid, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_ovr", bus.overrun, 1'b0);
        check("arst_ferr", bus.frame_err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        got_q = bus.Q;
        check("post_rst_q", got_q, 8'h5A);
        check("post_rst_valid", bus.valid, 1'b1);
        pulse_ack(1'b0);

        // TimerWidth=8 receiver
        send_frame(8'h00, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        got_q = bus8.Q;
        check("tw8_q00", got_q, 8'h00);
        check("tw8_v00", bus8.valid, 1'b1);
        pulse_ack(1'b1);
        check("tw8_ack_v", bus8.valid, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        got_q = bus8.Q;
        check("tw8_qff", got_q, 8'hFF);
        check("tw8_vff", bus8.valid, 1'b1);
        check("tw8_ovr", bus8.overrun, 1'b0);
        pulse_ack(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

UART-style serial receiver; the receive end of the SerialTx link. Deserialises one frame (start bit 0, Width data bits, stop bit 1) from asynchronous line `rx` at a fixed bit period of 2^TimerWidth clocks, and presents the word on a level-valid/ack handshake with frame-error and overrun flags. Sits between the external serial pin and the consumer logic of the IO subsystem.

## Interface
- Width, 8, data bits per frame
- TimerWidth, 8, bit period = 2^TimerWidth clk cycles; legal range ≥ 2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial line, asynchronous to clk, idle high
- ack  in  1  consumer has taken Q; clears valid
- Q  out  [0:Width-1]  last good word; bit order identical to SerialTx D
- valid  out  1  Q holds an unread word
- busy  out  1  frame reception in progress (states START..STOP)
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  sticky: good frame completed while valid=1; cleared by ack

## Operation
- rx passes through a 2-flop synchroniser; all logic uses synchronised `rxs`.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rxs=0 → START, timer cleared.
- START: when timer = 2^(TimerWidth-1)-1 (mid-bit): rxs=0 → DATA, timer cleared, bit counter 0; rxs=1 → IDLE (glitch reject, no flag).
- DATA: on timer all-ones, sample rxs into shift register; timer wraps to 0. After Width samples → STOP.
- Bit order: first data bit on the line → Q[Width-1], last → Q[0] (SerialTx D reproduced exactly).
- STOP: on timer all-ones, sample rxs. 1 → load Q, set valid, → IDLE. 0 → pulse frame_err, Q/valid unchanged, → WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then → IDLE (no re-arm on a held-low/break line).
- Handshake: valid set on good frame, cleared by ack. ack while valid=0 ignored. Good frame with valid=1 already: Q overwritten, valid stays 1, overrun set. Same-cycle ack and new load: valid stays 1, overrun not set (old word consumed), overrun cleared.
- ack clears overrun.
- Timer is TimerWidth bits, wraps modulo 2^TimerWidth; bit counter is clog2(Width+1) bits.

## Timing
- Reset (async): state IDLE, Q=0, valid=0, busy=0, frame_err=0, overrun=0, timer/bit counter 0. rst mid-frame aborts silently; next frame requires a fresh falling edge.
- Synchroniser latency 2 cycles from rx edge to rxs.
- Start sampled 2^(TimerWidth-1) cycles after IDLE→START; each data/stop sample exactly 2^TimerWidth cycles after the previous.
- valid rises and Q updates on the cycle after the stop-bit sample clock edge (registered); frame_err pulse same cycle.
- busy asserted from cycle after start detection through the stop-sample cycle; 0 in IDLE and WAIT_IDLE.
- Back-to-back frames: STOP→IDLE at mid-stop bit, so a next start bit immediately after a 1-bit stop is caught; SerialTx's longer stop period is accepted.
- Tolerates ±(40/(Width+2))% clock mismatch between ends.

## Structure
- Shared package serial_pkg: state enum (IDLE, START, DATA, STOP, WAIT_IDLE), shared with any future serial blocks; helper for bit-period constant.
- Sub-module serial_sync: 2-flop synchroniser with reset value 1 (idle line), reusable for other async inputs.
- RTL target ~150–200 lines.

## Test plan
Width=8, TimerWidth=4 (16 clk/bit) unless noted.
- Loopback with SerialTx, D=8'hA5 → after one frame valid=1, Q=8'hA5, frame_err=0; ack → valid=0.
- Drive rx low for 5 cycles only → no state beyond START, busy returns 0, valid stays 0.
- Frame 8'h3C with stop bit forced 0 → frame_err single-cycle pulse, valid=0, Q unchanged; rx held low 100 cycles → no new frame; rx high then valid frame 8'h11 → Q=8'h11.
- Two frames 8'h01, 8'hFE without ack → Q=8'hFE, valid=1, overrun=1; ack → valid=0, overrun=0.
- ack asserted on exact cycle second frame loads → valid=1, overrun=0, Q=second word.
- rst asserted mid-data of frame 8'hFF → all outputs 0 immediately; subsequent frame 8'h5A received correctly; repeat with TimerWidth=8 SerialTx loopback, D=8'h00 and 8'hFF.
